parity_gen_chk_pipe: RTL and testbench

//  Pipelined, parametrised parity generator/checker on a valid/ready word stream.
//  - Per beat: computes even/odd parity of an N-bit word and checks it against a received parity bit.
//  - Per frame (delimited by last): accumulates frame parity and beat count.
//  - Counts mismatches.
//  - Sits between a link receiver and downstream consumers; replaces the combinational odd-parity generator.

---
 rtl/parity_gen_chk_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_parity_gen_chk_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_gen_chk_pipe.sv
// parity_gen_chk_pipe
// Single-stage registered parity generator/checker on a valid/ready word
// stream. Each beat gets its word parity generated and checked against the
// received parity bit. A small frame FSM accumulates parity and beat count
// across a frame delimited by in_last. Mismatches are counted in a
// saturating error counter with a sticky flag.
//
// The output stage is one skid-less register: a new beat is accepted
// whenever the register is empty or is being drained in the same cycle, so
// the only combinational path is out_ready -> in_ready.

module parity_gen_chk_pipe #(
    parameter int N     = 8,
    parameter int ERR_W = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             odd_mode,
    input  logic             clr_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_parity,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_parity,
    output logic             out_err,
    output logic             out_last,
    output logic             out_frame_parity,
    output logic [LEN_W-1:0] out_frame_len,
    output logic [ERR_W-1:0] err_count,
    output logic             sticky_err
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             acc_q, acc_d;            // running XOR of data bits in frame
    logic [LEN_W-1:0] len_q, len_d;            // beats seen so far in frame

    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_data_q, out_data_d;
    logic             out_parity_q, out_parity_d;
    logic             out_err_q, out_err_d;
    logic             out_last_q, out_last_d;
    logic             out_fpar_q, out_fpar_d;
    logic [LEN_W-1:0] out_flen_q, out_flen_d;

    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             sticky_q, sticky_d;

    // ------------------------------------------------------------------
    // Beat-level combinational terms
    // ------------------------------------------------------------------
    logic             accept;
    logic             word_par;                // plain XOR of the data word
    logic             gen_par;                 // word parity in the selected mode
    logic             mismatch;
    logic [LEN_W-1:0] len_inc;                 // saturating len_q + 1
    logic             frame_par_nxt;
    logic [LEN_W-1:0] frame_len_nxt;

    // Handshake and per-word parity; in_ready only looks at the output register
    // and out_ready, never at in_valid, so no loop forms through upstream.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        word_par = ^in_data;
        gen_par  = word_par ^ odd_mode;
        mismatch = in_parity ^ gen_par;
        len_inc  = (len_q == LEN_MAX) ? len_q : len_q + LEN_ONE;
    end

    // Frame FSM next state: advances only on accepted beats; also yields the
    // frame summary that the output register captures with a last beat.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        len_d         = len_q;
        frame_par_nxt = 1'b0;
        frame_len_nxt = '0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (in_last) begin
                        // Single-beat frame: nothing accumulated yet.
                        frame_par_nxt = gen_par;
                        frame_len_nxt = LEN_ONE;
                    end else begin
                        state_d = IN_FRAME;
                        acc_d   = word_par;
                        len_d   = LEN_ONE;
                    end
                end
                IN_FRAME: begin
                    if (in_last) begin
                        // Mode of the closing beat decides the frame parity sense.
                        frame_par_nxt = acc_q ^ gen_par;
                        frame_len_nxt = len_inc;
                        state_d       = IDLE;
                        acc_d         = 1'b0;
                        len_d         = '0;
                    end else begin
                        acc_d = acc_q ^ word_par;
                        len_d = len_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = 1'b0;
                    len_d   = '0;
                end
            endcase
        end
    end

    // Frame FSM and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
        end
    end

    // Output register next state: load on accept, otherwise hold the beat
    // until it is taken, then drop valid. Payload is left in place once taken.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        out_err_d    = out_err_q;
        out_last_d   = out_last_q;
        out_fpar_d   = out_fpar_q;
        out_flen_d   = out_flen_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = in_data;
            out_parity_d = gen_par;
            out_err_d    = mismatch;
            out_last_d   = in_last;
            out_fpar_d   = frame_par_nxt;
            out_flen_d   = frame_len_nxt;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_err_q    <= 1'b0;
            out_last_q   <= 1'b0;
            out_fpar_q   <= 1'b0;
            out_flen_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            out_err_q    <= out_err_d;
            out_last_q   <= out_last_d;
            out_fpar_q   <= out_fpar_d;
            out_flen_q   <= out_flen_d;
        end
    end

    // Error statistics next state: a clear in the same cycle as a bad beat
    // wins, so that beat is not counted (its out_err still flags it).
    always_comb begin
        err_count_d = err_count_q;
        sticky_d    = sticky_q;
        if (clr_err) begin
            err_count_d = '0;
            sticky_d    = 1'b0;
        end else if (accept && mismatch) begin
            err_count_d = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + ERR_ONE;
            sticky_d    = 1'b1;
        end
    end

    // Error statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
            sticky_q    <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign out_parity       = out_parity_q;
    assign out_err          = out_err_q;
    assign out_last         = out_last_q;
    assign out_frame_parity = out_fpar_q;
    assign out_frame_len    = out_flen_q;
    assign err_count        = err_count_q;
    assign sticky_err       = sticky_q;

endmodule

// File: tb/tb_parity_gen_chk_pipe.sv
// Scoreboard bench for parity_gen_chk_pipe. Accepted beats are turned into
// expected output records by a frame-level reference model (set-bit counts
// over the whole frame) and queued; an independent monitor pops and compares
// whenever the DUT hands over an output beat.

module tb_parity_gen_chk_pipe;

    localparam int N     = 8;
    localparam int ERR_W = 8;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             odd_mode, clr_err, in_valid, in_parity, in_last, out_ready;
    logic [N-1:0]     in_data;
    logic             in_ready, out_valid, out_parity, out_err, out_last, out_frame_parity;
    logic [N-1:0]     out_data;
    logic [LEN_W-1:0] out_frame_len;
    logic [ERR_W-1:0] err_count;
    logic             sticky_err;

    parity_gen_chk_pipe #(.N(N), .ERR_W(ERR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .odd_mode(odd_mode), .clr_err(clr_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_parity(in_parity), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity(out_parity), .out_err(out_err), .out_last(out_last),
        .out_frame_parity(out_frame_parity), .out_frame_len(out_frame_len),
        .err_count(err_count), .sticky_err(sticky_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]     data;
        logic             par;
        logic             err;
        logic             last;
        logic             fpar;
        logic [LEN_W-1:0] flen;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] fr_q[$];      // words of the frame in progress
    int           exp_err    = 0;
    logic         exp_sticky = 1'b0;
    int           n_chk  = 0;
    int           n_pass = 0;
    bit           rand_ready = 1'b0;
    logic         last_ov;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: on every accepted beat build the expected output record.
    always @(negedge clk) begin : model
        exp_t e;
        int   ones;
        if (rst) begin
            fr_q.delete();
            exp_err    = 0;
            exp_sticky = 1'b0;
        end else begin
            chk("err_count", err_count, exp_err);
            chk("sticky_err", sticky_err, exp_sticky);
            if (in_valid && in_ready) begin
                e.data = in_data;
                e.par  = (($countones(in_data) % 2) == 1) ^ odd_mode;
                e.err  = (in_parity != e.par);
                e.last = in_last;
                if (in_last) begin
                    ones = $countones(in_data);
                    foreach (fr_q[i]) ones += $countones(fr_q[i]);
                    e.fpar = ((ones % 2) == 1) ^ odd_mode;
                    e.flen = (fr_q.size() + 1 > 255) ? 8'd255 : 8'(fr_q.size() + 1);
                    fr_q.delete();
                end else begin
                    e.fpar = 1'b0;
                    e.flen = '0;
                    fr_q.push_back(in_data);
                end
                exp_q.push_back(e);
                if (e.err && !clr_err) begin
                    if (exp_err < 255) exp_err++;
                    exp_sticky = 1'b1;
                end
            end
            if (clr_err) begin
                exp_err    = 0;
                exp_sticky = 1'b0;
            end
        end
    end

    // Monitor: compare on output handshake; check stability across stalls.
    logic             prev_stall = 1'b0;
    logic [N-1:0]     h_data;
    logic             h_par, h_err, h_last, h_fpar;
    logic [LEN_W-1:0] h_flen;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, h_data);
                chk("stall_bits", {out_parity, out_err, out_last, out_frame_parity},
                    {h_par, h_err, h_last, h_fpar});
                chk("stall_flen", out_frame_len, h_flen);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_parity", out_parity, e.par);
                    chk("out_err", out_err, e.err);
                    chk("out_last", out_last, e.last);
                    chk("out_frame_parity", out_frame_parity, e.fpar);
                    chk("out_frame_len", out_frame_len, e.flen);
                end
            end
            prev_stall = out_valid && !out_ready;
            h_data = out_data; h_par = out_parity; h_err = out_err;
            h_last = out_last; h_fpar = out_frame_parity; h_flen = out_frame_len;
        end
    end

    // Random downstream back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [N-1:0] d, input logic p, input logic l,
                        input logic m, input logic c);
        int n = 0;
        bit acc;
        in_valid = 1'b1; in_data = d; in_parity = p; in_last = l;
        odd_mode = m; clr_err = c;
        do begin
            @(negedge clk);
            acc     = in_ready;
            last_ov = out_valid;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0; clr_err = 1'b0;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin @(posedge clk); #1; end
    endtask

    function automatic logic good_par(input logic [N-1:0] d, input logic m);
        return (($countones(d) % 2) == 1) ^ m;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [N-1:0] d;
        logic         m, bad;
        rst = 1'b1; odd_mode = 0; clr_err = 0; in_valid = 0; in_data = '0;
        in_parity = 0; in_last = 0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_err_count", err_count, 0);
        rst = 1'b0;
        idle(2);

        // 1: single-beat frame 0xA5, even, parity 0
        send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_parity", out_parity, 0);
        chk("t1_err", out_err, 0);
        chk("t1_fpar", out_frame_parity, 0);
        chk("t1_flen", out_frame_len, 1);
        @(posedge clk); #1;

        // 2: odd mode, 0x00..0x0F, back-to-back with out_ready=1
        for (int i = 0; i < 16; i++) begin
            send(8'(i), good_par(8'(i), 1'b1), (i == 15), 1'b1, 1'b0);
            if (i > 0) chk("t2_no_bubble", last_ov, 1);
        end
        @(negedge clk);
        chk("t2_err_count", err_count, 0);
        @(posedge clk); #1;

        // 3: three-beat frame 0x01,0x03,0x07 even; six set bits -> parity 0
        send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_b1_flen", out_frame_len, 0);
        @(posedge clk); #1;
        send(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_fpar", out_frame_parity, 0);
        chk("t3_flen", out_frame_len, 3);
        @(posedge clk); #1;

        // 4: stall 5 cycles with a beat waiting
        idle(2);
        out_ready = 1'b0;
        send(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'hC3; in_parity = 1'b0; in_last = 1'b1; odd_mode = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_in_ready", in_ready, 0);
            chk("t4_hold_data", out_data, 8'h3C);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_second_beat", out_data, 8'hC3);
        @(posedge clk); #1;

        // 5: 300 bad beats in one long frame -> counters saturate, then clear
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom); m = 1'($urandom);
            send(d, ~good_par(d, m), 1'b0, m, 1'b0);
        end
        @(negedge clk);
        chk("t5_err_sat", err_count, 255);
        chk("t5_sticky", sticky_err, 1);
        @(posedge clk); #1;
        send(8'h11, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t5_clr_count", err_count, 0);
        chk("t5_clr_sticky", sticky_err, 0);
        chk("t5_clr_out_err", out_err, 1);
        chk("t5_len_sat", out_frame_len, 255);
        @(posedge clk); #1;

        // 6: reset mid-frame
        send(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_flen", out_frame_len, 0);
        chk("t6_rst_sticky", sticky_err, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_flen", out_frame_len, 1);
        @(posedge clk); #1;

        // Random traffic with back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            d = 8'($urandom); m = 1'($urandom); bad = ($urandom_range(0, 7) == 0);
            send(d, good_par(d, m) ^ bad, ($urandom_range(0, 3) == 0), m,
                 ($urandom_range(0, 29) == 0));
        end

        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle(3);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
